// File: rtl/dmem_responder.sv
// Data-memory responder: serves byte/half/word loads and stores from a word-organised RAM
// with a programmable number of wait states ahead of each RAM access.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a request; req_* latched on req_valid
// S_WAIT   | wait-state down-counter running toward terminal count
// S_ACCESS | single RAM cycle: store commits, load data is extended
// S_ERR    | misaligned request; no RAM effect, error response built
// S_RESP   | response held until rsp_ready
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        CLR_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_half,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ERR,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  byte_q, byte_d;
    logic                  half_q, half_d;
    logic                  uns_q, uns_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_ext;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;
    logic                  mem_we;
    logic                  req_misaligned;

    // Address bits above the RAM are don't-care, which makes addresses wrap.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign lane     = addr_q[1:0];
    assign rd_word  = mem[word_idx];
    assign mem_we   = (state_q == S_ACCESS) && we_q;

    assign req_misaligned = req_byte ? 1'b0 :
                            req_half ? req_addr[0] :
                                       (req_addr[1:0] != 2'b00);

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

        if (byte_q) begin
            load_ext = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        end else if (half_q) begin
            load_ext = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
        end else begin
            load_ext = rd_word;
        end
    end

    // Store data is replicated across lanes so each byte enable just picks its lane.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
        if (byte_q) begin
            wr_be   = 4'b0001 << lane;
            wr_data = {4{wdata_q[7:0]}};
        end else if (half_q) begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata_q[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        byte_d      = byte_q;
        half_d      = half_q;
        uns_d       = uns_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    addr_d      = req_addr[ADDR_WIDTH+1:0];
                    wdata_d     = req_wdata;
                    we_d        = req_we;
                    byte_d      = req_byte;
                    half_d      = req_half & ~req_byte;
                    uns_d       = req_unsigned;
                    req_ready_d = 1'b0;
                    if (req_misaligned) begin
                        state_d = S_ERR;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = we_q ? 32'd0 : load_ext;
                state_d     = S_RESP;
            end
            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = 32'd0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            half_q      <= 1'b0;
            uns_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            half_q      <= half_d;
            uns_q       <= uns_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_WIDTH=10, WAIT_CYCLES=2) with hand-computed expectations.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        CLR_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        req_byte;
    logic        req_half;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .CLR_n        (CLR_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_we       (req_we),
        .req_byte     (req_byte),
        .req_half     (req_half),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency from the accept edge, optionally stall RESP for
    // 'hold' extra cycles, then hand-shake and confirm the return to IDLE.
    task automatic do_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic bt, input logic hf, input logic un,
                          input int hold, output logic [31:0] rdata, output logic err,
                          output int lat);
        int   n;
        logic rdy_seen;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        req_valid    = 1'b1;
        req_addr     = addr;
        req_wdata    = wdata;
        req_we       = we;
        req_byte     = bt;
        req_half     = hf;
        req_unsigned = un;
        step();
        req_valid = 1'b0;
        lat       = 1;
        rdy_seen  = 1'b0;
        while (!rsp_valid && lat < 50) begin
            if (req_ready) rdy_seen = 1'b1;
            step();
            lat++;
        end
        if (req_ready) rdy_seen = 1'b1;
        if (!rsp_valid) lat = 99;
        chk({tag, " ready_low"}, 32'(rdy_seen), 32'd0);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold_rdata"}, rsp_rdata, rdata);
            chk({tag, " hold_err"}, 32'(rsp_err), 32'(err));
            chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " idle_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic we, input logic bt, input logic hf, input logic un,
                             input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lt;
        do_req(tag, addr, wdata, we, bt, hf, un, 0, rd, er, lt);
        chk({tag, " rdata"}, rd, exp_data);
        chk({tag, " err"}, 32'(er), 32'(exp_err));
        chk({tag, " latency"}, 32'(lt), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic        seen_valid;

        CLR_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_we       = 1'b0;
        req_byte     = 1'b0;
        req_half     = 1'b0;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;
        repeat (3) step();
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        CLR_n = 1'b1;
        step();

        //        tag            addr       wdata         we  bt  hf  un  data          err lat
        check_rsp("st_w 10",     32'h10,    32'hDEADBEEF, 1,  0,  0,  0,  32'h00000000, 0,  4);
        check_rsp("ld_w 10",     32'h10,    32'h0,        0,  0,  0,  0,  32'hDEADBEEF, 0,  4);
        check_rsp("st_w 10 z",   32'h10,    32'h00000000, 1,  0,  0,  0,  32'h00000000, 0,  4);
        check_rsp("st_b 11",     32'h11,    32'hFFFFFF80, 1,  1,  0,  0,  32'h00000000, 0,  4);
        check_rsp("ld_bs 11",    32'h11,    32'h0,        0,  1,  0,  0,  32'hFFFFFF80, 0,  4);
        check_rsp("ld_bu 11",    32'h11,    32'h0,        0,  1,  0,  1,  32'h00000080, 0,  4);
        check_rsp("ld_w 10 b",   32'h10,    32'h0,        0,  0,  0,  1,  32'h00008000, 0,  4);
        check_rsp("ld_bh 11",    32'h11,    32'h0,        0,  1,  1,  1,  32'h00000080, 0,  4);
        check_rsp("st_w 20 z",   32'h20,    32'h00000000, 1,  0,  0,  0,  32'h00000000, 0,  4);
        check_rsp("st_h 22",     32'h22,    32'h5555ABCD, 1,  0,  1,  0,  32'h00000000, 0,  4);
        check_rsp("ld_hs 22",    32'h22,    32'h0,        0,  0,  1,  0,  32'hFFFFABCD, 0,  4);
        check_rsp("ld_hu 20",    32'h20,    32'h0,        0,  0,  1,  1,  32'h00000000, 0,  4);
        check_rsp("ld_w 13 mis", 32'h13,    32'h0,        0,  0,  0,  0,  32'h00000000, 1,  2);
        check_rsp("st_h 21 mis", 32'h21,    32'h00001111, 1,  0,  1,  0,  32'h00000000, 1,  2);
        check_rsp("ld_w 20",     32'h20,    32'h0,        0,  0,  0,  0,  32'hABCD0000, 0,  4);

        do_req("bp ld 10", 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5, rd, er, lt);
        chk("bp rdata", rd, 32'h00008000);
        chk("bp err", 32'(er), 32'd0);

        check_rsp("st_w 30",     32'h30,    32'hCAFEF00D, 1,  0,  0,  0,  32'h00000000, 0,  4);

        req_valid = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_half  = 1'b0;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        CLR_n     = 1'b0;
        step();
        CLR_n = 1'b1;
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        seen_valid = 1'b0;
        repeat (6) begin
            step();
            if (rsp_valid) seen_valid = 1'b1;
        end
        chk("midrst no_rsp", 32'(seen_valid), 32'd0);

        check_rsp("ld_w 30 kept", 32'h30,   32'h0,        0,  0,  0,  0,  32'hCAFEF00D, 0,  4);
        check_rsp("ld_w 1030",    32'h1030, 32'h0,        0,  0,  0,  0,  32'hCAFEF00D, 0,  4);
        check_rsp("st_w 1034",    32'h1034, 32'h5A5A1234, 1,  0,  0,  0,  32'h00000000, 0,  4);
        check_rsp("ld_w 34",      32'h34,   32'h0,        0,  0,  0,  0,  32'h5A5A1234, 0,  4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
